// File: rtl/bo_pkg.sv
// Shared definitions for the polynomial-datapath scheduler and its controle wiring.
package bo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int W_BO       = 8;
  localparam int TIMEOUT_BO = 15;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module arbitro_rr
  import bo_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PW-1:0]    pick_idx,
  output logic             any
);

  logic [PW-1:0] idx;

  always_comb begin
    pick_idx = '0;
    idx      = '0;
    any      = |req;
    // Scan from the farthest offset down so the closest-to-ptr request wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (req[idx]) pick_idx = idx;
    end
    pick = any ? (N_REQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/escalonador_bo.sv
// Round-robin scheduler sharing one polynomial datapath/controle pair between requesters.
//   state   | meaning
//   S_IDLE  | no operation; arbitrate pending requests
//   S_START | gnt and dp_inicio high for this single cycle
//   S_WAIT  | wait for dp_pronto, watchdog counting
//   S_DONE  | ack to owner with res_out/err valid
module escalonador_bo
  import bo_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = W_BO,
  parameter int TIMEOUT = TIMEOUT_BO
) (
  input  logic               ck,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] x_req,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       res_out,
  output logic               err,
  output logic               busy,
  output logic               dp_inicio,
  output logic [W-1:0]       dp_x,
  input  logic               dp_pronto,
  input  logic [W-1:0]       dp_res
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  state_t             state_q;
  logic [PW-1:0]      ptr_q, ptr_d, owner_q;
  logic [CW-1:0]      cnt_q;
  logic [W-1:0]       x_q, res_q, x_pick;
  logic [N_REQ-1:0]   gnt_q, ack_q, pick;
  logic               err_q, busy_q, inicio_q, any;
  logic [PW-1:0]      pick_idx;

  arbitro_rr #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  always_comb begin
    x_pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i)) x_pick = x_req[i*W +: W];
    end
  end

  assign ptr_d = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + PW'(1);

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      res_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      inicio_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any) begin
            x_q      <= x_pick;
            owner_q  <= pick_idx;
            gnt_q    <= pick;
            inicio_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          gnt_q    <= '0;
          inicio_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes precedence over the watchdog on the last cycle.
          if (dp_pronto) begin
            res_q   <= dp_res;
            err_q   <= 1'b0;
            ack_q   <= N_REQ'(1) << owner_q;
            state_q <= S_DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            ack_q   <= N_REQ'(1) << owner_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign res_out   = res_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign dp_inicio = inicio_q;
  assign dp_x      = x_q;

endmodule

// File: tb/tb_escalonador_bo.sv
// Scoreboard bench for escalonador_bo: directed scenarios followed by randomized traffic.
module tb_escalonador_bo;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int TO = 15;

  logic           ck = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] x_req = '0;
  logic           dp_pronto = 1'b0;
  logic [W-1:0]   dp_res = '0;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   res_out, dp_x;
  logic           err, busy, dp_inicio;

  escalonador_bo #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .ck(ck), .rst(rst), .req(req), .x_req(x_req), .gnt(gnt), .ack(ack),
    .res_out(res_out), .err(err), .busy(busy), .dp_inicio(dp_inicio),
    .dp_x(dp_x), .dp_pronto(dp_pronto), .dp_res(dp_res)
  );

  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         e;
    int           c;
  } exp_t;

  exp_t exp_q[$];
  int   own_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tmo_cnt = 0;
  int   force_lat = 10;
  bit   end_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Datapath responder: answers each start after L WAIT cycles (or never, if L > TO)
  initial begin : responder
    int   lat;
    bit   ab;
    exp_t it;
    logic [W-1:0] r;
    forever begin
      @(negedge ck);
      if (!rst) begin
        dp_pronto = 1'b0;
        continue;
      end
      if (dp_inicio) begin
        dp_pronto = 1'b0;
        lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 18));
        r = W'($urandom_range(1, 255));
        it.res = (lat <= TO) ? r : '0;
        it.e   = (lat > TO);
        it.c   = cyc + ((lat <= TO) ? lat + 1 : TO + 1);
        exp_q.push_back(it);
        ab = 1'b0;
        for (int k = 0; k < lat && k < TO; k++) begin
          @(negedge ck);
          if (!rst) begin
            ab = 1'b1;
            break;
          end
        end
        if (!ab && lat <= TO) begin
          dp_res = r;
          dp_pronto = 1'b1;
          @(negedge ck);
        end
        dp_pronto = 1'b0;
      end else begin
        dp_pronto = ($urandom_range(0, 5) == 0);
        dp_res = W'($urandom);
      end
    end
  end

  initial begin : monitor
    logic [N-1:0]   prev_req;
    logic [N*W-1:0] prev_x;
    logic [W-1:0]   last_res;
    bit   prev_idle, prev_ack, cur_idle, exp_g, exp_a;
    int   mptr, w, o;
    exp_t e;
    prev_req = '0; prev_x = '0; last_res = '0;
    prev_idle = 1'b0; prev_ack = 1'b1; mptr = 0;
    forever begin
      @(negedge ck);
      if (end_req) break;
      if (!rst) begin
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dp_inicio", 32'(dp_inicio), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_res_out", 32'(res_out), 0);
        chk("rst_dp_x", 32'(dp_x), 0);
        own_q.delete();
        exp_q.delete();
        mptr = 0; last_res = '0;
        prev_idle = 1'b0; prev_ack = 1'b1;
        prev_req = req; prev_x = x_req;
        continue;
      end
      exp_g    = prev_idle && (prev_req != '0);
      cur_idle = prev_idle ? (prev_req == '0) : prev_ack;
      w        = exp_g ? rr_pick(prev_req, mptr) : 0;
      chk("gnt", 32'(gnt), exp_g ? (32'd1 << w) : 32'd0);
      chk("dp_inicio", 32'(dp_inicio), 32'(exp_g));
      chk("busy", 32'(busy), 32'(!cur_idle));
      if (exp_g) begin
        chk("dp_x", 32'(dp_x), 32'(prev_x[w*W +: W]));
        own_q.push_back(w);
      end
      exp_a = (exp_q.size() > 0) && (exp_q[0].c == cyc);
      if (exp_a) begin
        e = exp_q.pop_front();
        o = (own_q.size() > 0) ? own_q.pop_front() : 0;
        chk("ack", 32'(ack), 32'd1 << o);
        chk("res_out", 32'(res_out), 32'(e.res));
        chk("err", 32'(err), 32'(e.e));
        last_res = e.res;
        mptr = (o + 1) % N;
      end else begin
        chk("ack_quiet", 32'(ack), 0);
        chk("err_quiet", 32'(err), 0);
        chk("res_out_hold", 32'(res_out), 32'(last_res));
      end
      prev_ack = exp_a; prev_idle = cur_idle;
      prev_req = req; prev_x = x_req;
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("owner_queue_empty", 32'(own_q.size()), 0);
    chk("budget_expiries", 32'(tmo_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic run_ops(input int n, input bit hold);
    int got = 0;
    int t = 0;
    while (got < n && t < 400) begin
      @(posedge ck); #1;
      t++;
      if (ack != '0) begin
        got++;
        if (!hold) req = req & ~ack;
      end
    end
    if (got < n) begin
      tmo_cnt++;
      $display("FAIL run_ops_budget: got %0d acks, required %0d", got, n);
    end
  endtask

  task automatic wait_gnt();
    int t = 0;
    do begin
      @(posedge ck); #1;
      t++;
    end while (gnt == '0 && t < 50);
    if (gnt == '0) begin
      tmo_cnt++;
      $display("FAIL wait_gnt_budget: got gnt=0, required a grant");
    end
  endtask

  task automatic run_random(input int ncyc);
    bit [N-1:0] pend = '0;
    int cool[N];
    int t = 0;
    for (int i = 0; i < N; i++) cool[i] = 0;
    while ((t < ncyc || pend != '0) && t < ncyc + 2000) begin
      @(posedge ck); #1;
      t++;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && ack[i]) begin
          pend[i] = 1'b0;
          req[i] = 1'b0;
          cool[i] = $urandom_range(0, 3);
        end else if (pend[i] && gnt[i] && req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b0;
        end else if (!pend[i] && t < ncyc) begin
          if (cool[i] == 0) begin
            pend[i] = 1'b1;
            req[i] = 1'b1;
            x_req[i*W +: W] = W'($urandom);
          end else begin
            cool[i]--;
          end
        end
      end
    end
    if (pend != '0) begin
      tmo_cnt++;
      $display("FAIL random_drain_budget: got pending=0x%0h, required 0x0", pend);
    end
  endtask

  initial begin : main
    #1 rst = 1'b0;
    repeat (3) @(posedge ck);
    // Both requesters from reset, held high: strict alternation 0,1,0,1
    req = 2'b11;
    x_req = {8'h02, 8'h01};
    @(posedge ck); #2 rst = 1'b1;
    run_ops(4, 1'b1);
    req = '0;
    // Single request with nominal latency
    x_req[7:0] = 8'h05;
    req = 2'b01;
    run_ops(1, 1'b0);
    // Watchdog expiry, then completion on the last WAIT cycle
    force_lat = 100;
    req = 2'b01;
    run_ops(1, 1'b0);
    force_lat = TO;
    x_req[7:0] = 8'h3C;
    req = 2'b01;
    run_ops(1, 1'b0);
    // Move ptr to 1, then reset in the middle of requester 1's WAIT
    force_lat = 10;
    req = 2'b01;
    run_ops(1, 1'b0);
    force_lat = 100;
    x_req[15:8] = 8'h77;
    req = 2'b10;
    wait_gnt();
    repeat (5) @(posedge ck);
    #2 rst = 1'b0;
    req = 2'b11;
    @(posedge ck); #2 rst = 1'b1;
    force_lat = 10;
    run_ops(2, 1'b0);
    req = '0;
    // Randomized traffic and latencies
    force_lat = 0;
    run_random(3000);
    repeat (25) @(posedge ck);
    end_req = 1'b1;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
